// File: rtl/router_nx_top.sv
// Parametrised 1-to-N byte-serial packet router with per-port FIFOs,
// invalid-destination drop, parity/length checking and stall-timeout flush.
module router_nx_top #(
    parameter int DATA_W     = 8,
    parameter int NUM_PORTS  = 3,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 30
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          pkt_valid,
    input  logic [DATA_W-1:0]             data_in,
    input  logic [NUM_PORTS-1:0]          read_enb,
    output logic [NUM_PORTS*DATA_W-1:0]   data_out,
    output logic [NUM_PORTS-1:0]          valid_out,
    output logic [NUM_PORTS-1:0]          soft_reset,
    output logic                          busy,
    output logic                          error,
    output logic                          drop
);

    localparam int ADDR_W = $clog2(NUM_PORTS);
    localparam int LEN_W  = DATA_W - ADDR_W;
    localparam int CNT_W  = LEN_W + 1;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = AW + 1;
    localparam int TO_W   = $clog2(TIMEOUT);
    localparam int DEC_N  = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_EMPTY,
        DROP
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   dest_q;
    logic [LEN_W-1:0]    len_q;
    logic [DATA_W-1:0]   hdr_q;
    logic [DATA_W-1:0]   parity_q;
    logic [CNT_W-1:0]    count_q;

    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] wr_en;
    logic [NUM_PORTS-1:0] rd_en;
    logic [NUM_PORTS-1:0] flush;
    logic [DEC_N-1:0]     full_ext;
    logic [DEC_N-1:0]     empty_ext;

    logic [ADDR_W-1:0]    hdr_dest;
    logic                 hdr_dest_ok;
    logic                 wr_any;
    logic [ADDR_W-1:0]    wr_dest;
    logic [DATA_W-1:0]    wr_data;

    assign hdr_dest    = data_in[ADDR_W-1:0];
    assign hdr_dest_ok = (32'(hdr_dest) < NUM_PORTS);

    // Unused decode slots read as empty and never full so any address indexes safely.
    always_comb begin
        full_ext  = '0;
        empty_ext = '1;
        for (int i = 0; i < NUM_PORTS; i++) begin
            full_ext[i]  = full[i];
            empty_ext[i] = empty[i];
        end
    end

    always_comb begin
        busy = 1'b0;
        case (state)
            IDLE:       busy = 1'b0;
            LOAD:       busy = full_ext[dest_q];
            WAIT_EMPTY: busy = 1'b1;
            DROP:       busy = 1'b0;
            default:    busy = 1'b0;
        endcase
    end

    always_comb begin
        wr_any  = 1'b0;
        wr_dest = dest_q;
        wr_data = data_in;
        case (state)
            IDLE: begin
                if (pkt_valid && hdr_dest_ok && empty_ext[hdr_dest]) begin
                    wr_any  = 1'b1;
                    wr_dest = hdr_dest;
                end
            end
            WAIT_EMPTY: begin
                if (empty_ext[dest_q]) begin
                    wr_any  = 1'b1;
                    wr_data = hdr_q;
                end
            end
            LOAD: begin
                if (pkt_valid && !full_ext[dest_q]) begin
                    wr_any = 1'b1;
                end
            end
            default: wr_any = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            dest_q   <= '0;
            len_q    <= '0;
            hdr_q    <= '0;
            parity_q <= '0;
            count_q  <= '0;
            error    <= 1'b0;
            drop     <= 1'b0;
        end else begin
            drop <= 1'b0;
            case (state)
                IDLE: begin
                    if (pkt_valid) begin
                        dest_q   <= hdr_dest;
                        len_q    <= data_in[DATA_W-1:ADDR_W];
                        hdr_q    <= data_in;
                        parity_q <= data_in;
                        count_q  <= '0;
                        error    <= 1'b0;
                        if (!hdr_dest_ok) begin
                            state <= DROP;
                        end else if (empty_ext[hdr_dest]) begin
                            state <= LOAD;
                        end else begin
                            state <= WAIT_EMPTY;
                        end
                    end
                end
                WAIT_EMPTY: begin
                    if (empty_ext[dest_q]) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (!full_ext[dest_q]) begin
                        if (pkt_valid) begin
                            parity_q <= parity_q ^ data_in;
                            // Saturate so an oversized packet still mismatches its length.
                            if (count_q != '1) begin
                                count_q <= count_q + CNT_W'(1);
                            end
                        end else begin
                            error <= (parity_q != data_in) || (count_q != {1'b0, len_q});
                            state <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (!pkt_valid) begin
                        drop  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        logic [DATA_W-1:0] mem [FIFO_DEPTH];
        logic [PTR_W-1:0]  wp;
        logic [PTR_W-1:0]  rp;
        logic [TO_W-1:0]   stall_cnt;
        logic [DATA_W-1:0] dout;
        logic              stall;

        assign empty[i]      = (wp == rp);
        assign full[i]       = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
        assign wr_en[i]      = wr_any && (wr_dest == ADDR_W'(i));
        assign rd_en[i]      = read_enb[i] && !empty[i];
        assign stall         = !empty[i] && !read_enb[i];
        assign flush[i]      = stall && (stall_cnt == TO_W'(TIMEOUT - 1));
        assign valid_out[i]  = !empty[i];
        assign soft_reset[i] = flush[i];
        assign data_out[i*DATA_W +: DATA_W] = dout;

        always_ff @(posedge clock) begin
            if (wr_en[i] && !flush[i]) begin
                mem[wp[AW-1:0]] <= wr_data;
            end
        end

        // A flush wins over a same-edge write; the write is simply lost.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                wp   <= '0;
                rp   <= '0;
                dout <= '0;
            end else if (flush[i]) begin
                wp <= '0;
                rp <= '0;
            end else begin
                if (wr_en[i]) begin
                    wp <= wp + PTR_W'(1);
                end
                if (rd_en[i]) begin
                    dout <= mem[rp[AW-1:0]];
                    rp   <= rp + PTR_W'(1);
                end
            end
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                stall_cnt <= '0;
            end else if (!stall || flush[i]) begin
                stall_cnt <= '0;
            end else begin
                stall_cnt <= stall_cnt + TO_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_router_nx_top.sv
// Directed bench for router_nx_top at default parameters (3 ports, 8-bit, depth 16, timeout 30).
module tb_router_nx_top;

    logic        clock;
    logic        reset;
    logic        pkt_valid;
    logic [7:0]  data_in;
    logic [2:0]  read_enb;
    logic [23:0] data_out;
    logic [2:0]  valid_out;
    logic [2:0]  soft_reset;
    logic        busy;
    logic        error;
    logic        drop;

    int vectors     = 0;
    int miscompares = 0;
    int busy_cycles = 0;
    int drop_cycles = 0;
    int sr2_cycles  = 0;

    router_nx_top #(
        .DATA_W(8),
        .NUM_PORTS(3),
        .FIFO_DEPTH(16),
        .TIMEOUT(30)
    ) dut (
        .clock(clock),
        .reset(reset),
        .pkt_valid(pkt_valid),
        .data_in(data_in),
        .read_enb(read_enb),
        .data_out(data_out),
        .valid_out(valid_out),
        .soft_reset(soft_reset),
        .busy(busy),
        .error(error),
        .drop(drop)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(negedge clock) begin
        if (busy) busy_cycles++;
        if (drop) drop_cycles++;
        if (soft_reset[2]) sr2_cycles++;
    end

    // Present a byte and hold it until the router accepts it; entered and left at posedge+1.
    task automatic send_byte(input logic v, input logic [7:0] b);
        int waited = 0;
        pkt_valid = v;
        data_in   = b;
        @(negedge clock);
        while (busy && waited < 200) begin
            waited++;
            @(negedge clock);
        end
        if (busy) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL send_timeout: busy still %b after %0d cycles, want 0", busy, waited);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic read_byte(input int p, output logic [7:0] d);
        read_enb    = 3'b000;
        read_enb[p] = 1'b1;
        @(posedge clock);
        #1;
        read_enb = 3'b000;
        d = data_out[p*8 +: 8];
    endtask

    task automatic test_reset();
        reset = 1'b1; pkt_valid = 1'b0; data_in = 8'h00; read_enb = 3'b000;
        repeat (2) @(posedge clock);
        #1;
        vectors++;
        if (valid_out !== 3'b000 || soft_reset !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_valid: got valid %b sr %b, want 000 000", valid_out, soft_reset);
        end
        vectors++;
        if (busy !== 1'b0 || error !== 1'b0 || drop !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got busy %b err %b drop %b, want 0 0 0", busy, error, drop);
        end
        vectors++;
        if (data_out !== 24'h000000) begin
            miscompares++;
            $display("[TB] FAIL reset_data: got %h want 000000", data_out);
        end
        reset = 1'b0;
        @(posedge clock);
        #1;
        vectors++;
        if (valid_out !== 3'b000 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_release: got valid %b busy %b, want 000 0", valid_out, busy);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp_bytes [4] = '{8'h0D, 8'h11, 8'h22, 8'h33};
        logic [7:0] got;
        int b0 = busy_cycles;
        send_byte(1'b1, 8'h0D);
        vectors++;
        if (valid_out !== 3'b010) begin
            miscompares++;
            $display("[TB] FAIL basic_valid: got %b want 010", valid_out);
        end
        send_byte(1'b1, 8'h11);
        send_byte(1'b1, 8'h22);
        send_byte(1'b1, 8'h33);
        send_byte(1'b0, 8'h0D);
        vectors++;
        if (error !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL basic_error: got %b want 0", error);
        end
        for (int i = 0; i < 4; i++) begin
            read_byte(1, got);
            vectors++;
            if (got !== exp_bytes[i]) begin
                miscompares++;
                $display("[TB] FAIL basic_read%0d: got %h want %h", i, got, exp_bytes[i]);
            end
        end
        vectors++;
        if (valid_out !== 3'b000 || busy_cycles != b0) begin
            miscompares++;
            $display("[TB] FAIL basic_end: got valid %b busy cycles %0d, want 000 0", valid_out, busy_cycles - b0);
        end
    endtask

    task automatic test_bad_packet();
        logic [7:0] exp_bytes [4] = '{8'h0D, 8'h11, 8'h22, 8'h33};
        logic [7:0] got;
        send_byte(1'b1, 8'h0D);
        send_byte(1'b1, 8'h11);
        send_byte(1'b1, 8'h22);
        send_byte(1'b1, 8'h33);
        send_byte(1'b0, 8'h0E);
        vectors++;
        if (error !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bad_parity: got %b want 1", error);
        end
        for (int i = 0; i < 4; i++) begin
            read_byte(1, got);
            vectors++;
            if (got !== exp_bytes[i]) begin
                miscompares++;
                $display("[TB] FAIL bad_read%0d: got %h want %h", i, got, exp_bytes[i]);
            end
        end
        vectors++;
        if (error !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bad_hold: got %b want 1", error);
        end
        send_byte(1'b1, 8'h0D);
        vectors++;
        if (error !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bad_clear: got %b want 0", error);
        end
        send_byte(1'b1, 8'h11);
        send_byte(1'b1, 8'h22);
        send_byte(1'b0, 8'h3E);
        vectors++;
        if (error !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bad_length: got %b want 1", error);
        end
        for (int i = 0; i < 3; i++) read_byte(1, got);
        vectors++;
        if (got !== 8'h22 || valid_out !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL bad_len_drain: got %h valid %b, want 22 000", got, valid_out);
        end
    endtask

    task automatic test_invalid_dest();
        int b0 = busy_cycles;
        int d0 = drop_cycles;
        send_byte(1'b1, 8'h0B);
        vectors++;
        if (valid_out !== 3'b000 || error !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL drop_hdr: got valid %b err %b, want 000 0", valid_out, error);
        end
        send_byte(1'b1, 8'hAA);
        send_byte(1'b1, 8'h55);
        send_byte(1'b0, 8'hF4);
        vectors++;
        if (drop !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL drop_pulse: got %b want 1", drop);
        end
        @(posedge clock);
        #1;
        vectors++;
        if (drop !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL drop_clear: got %b want 0", drop);
        end
        vectors++;
        if (drop_cycles - d0 != 1 || busy_cycles != b0 || valid_out !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL drop_summary: got drops %0d busy %0d valid %b, want 1 0 000",
                     drop_cycles - d0, busy_cycles - b0, valid_out);
        end
    endtask

    task automatic test_full_fifo();
        logic [7:0] got;
        logic [7:0] want;
        int idx = 0;
        send_byte(1'b1, 8'h50);
        for (int b = 1; b <= 15; b++) send_byte(1'b1, 8'(b));
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL full_busy: got %b want 1", busy);
        end
        pkt_valid = 1'b1;
        data_in   = 8'd16;
        @(posedge clock);
        #1;
        vectors++;
        if (busy !== 1'b1 || valid_out !== 3'b001) begin
            miscompares++;
            $display("[TB] FAIL full_hold: got busy %b valid %b, want 1 001", busy, valid_out);
        end
        for (int b = 16; b <= 21; b++) begin
            if (b == 21) begin
                pkt_valid = 1'b0;
                data_in   = 8'h44;
            end else begin
                data_in = 8'(b);
            end
            read_byte(0, got);
            want = (idx == 0) ? 8'h50 : 8'(idx);
            idx++;
            vectors++;
            if (got !== want || busy !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL full_release%0d: got data %h busy %b, want %h 0", b, got, busy, want);
            end
            @(posedge clock);
            #1;
            if (b < 21) begin
                vectors++;
                if (busy !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL full_refill%0d: got busy %b want 1", b, busy);
                end
            end
        end
        vectors++;
        if (error !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL full_parity: got err %b busy %b, want 0 0", error, busy);
        end
        while (idx < 21) begin
            read_byte(0, got);
            vectors++;
            if (got !== 8'(idx)) begin
                miscompares++;
                $display("[TB] FAIL full_drain%0d: got %h want %h", idx, got, 8'(idx));
            end
            idx++;
        end
        vectors++;
        if (valid_out !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL full_empty: got %b want 000", valid_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got;
        logic [7:0] exp_a [3] = '{8'h09, 8'hA1, 8'hA2};
        send_byte(1'b1, 8'h09);
        send_byte(1'b1, 8'hA1);
        send_byte(1'b1, 8'hA2);
        send_byte(1'b0, 8'h0A);
        send_byte(1'b1, 8'h05);
        vectors++;
        if (busy !== 1'b1 || valid_out !== 3'b010) begin
            miscompares++;
            $display("[TB] FAIL b2b_wait: got busy %b valid %b, want 1 010", busy, valid_out);
        end
        pkt_valid = 1'b1;
        data_in   = 8'hB7;
        for (int i = 0; i < 3; i++) begin
            read_byte(1, got);
            vectors++;
            if (got !== exp_a[i]) begin
                miscompares++;
                $display("[TB] FAIL b2b_read%0d: got %h want %h", i, got, exp_a[i]);
            end
        end
        vectors++;
        if (valid_out[1] !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_empty: got valid1 %b busy %b, want 0 1", valid_out[1], busy);
        end
        @(posedge clock);
        #1;
        vectors++;
        if (valid_out[1] !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_resume: got valid1 %b busy %b, want 1 0", valid_out[1], busy);
        end
        @(posedge clock);
        #1;
        send_byte(1'b0, 8'hB2);
        vectors++;
        if (error !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_error: got %b want 0", error);
        end
        read_byte(1, got);
        vectors++;
        if (got !== 8'h05) begin
            miscompares++;
            $display("[TB] FAIL b2b_hdr: got %h want 05", got);
        end
        read_byte(1, got);
        vectors++;
        if (got !== 8'hB7 || valid_out !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL b2b_payload: got %h valid %b, want b7 000", got, valid_out);
        end
    endtask

    task automatic test_timeout();
        int s0 = sr2_cycles;
        send_byte(1'b1, 8'h06);
        send_byte(1'b1, 8'h77);
        send_byte(1'b0, 8'h71);
        vectors++;
        if (error !== 1'b0 || soft_reset !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL to_packet: got err %b sr %b, want 0 000", error, soft_reset);
        end
        repeat (26) @(posedge clock);
        #1;
        vectors++;
        if (soft_reset[2] !== 1'b0 || valid_out[2] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL to_early: got sr2 %b valid2 %b, want 0 1", soft_reset[2], valid_out[2]);
        end
        @(posedge clock);
        #1;
        vectors++;
        if (soft_reset[2] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL to_pulse: got %b want 1", soft_reset[2]);
        end
        @(posedge clock);
        #1;
        vectors++;
        if (valid_out[2] !== 1'b0 || soft_reset !== 3'b000 || sr2_cycles - s0 != 1) begin
            miscompares++;
            $display("[TB] FAIL to_flush: got valid2 %b sr %b pulses %0d, want 0 000 1",
                     valid_out[2], soft_reset, sr2_cycles - s0);
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [7:0] got;
        send_byte(1'b1, 8'h0D);
        send_byte(1'b1, 8'h11);
        pkt_valid = 1'b1;
        data_in   = 8'h22;
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (valid_out !== 3'b000 || data_out !== 24'h000000 || soft_reset !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL rst_async: got valid %b data %h sr %b, want 000 000000 000",
                     valid_out, data_out, soft_reset);
        end
        vectors++;
        if (busy !== 1'b0 || error !== 1'b0 || drop !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rst_flags: got busy %b err %b drop %b, want 0 0 0", busy, error, drop);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        vectors++;
        if (valid_out !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL rst_new_hdr: got %b want 100", valid_out);
        end
        send_byte(1'b0, 8'h22);
        vectors++;
        if (error !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rst_len_err: got %b want 1", error);
        end
        read_byte(2, got);
        vectors++;
        if (got !== 8'h22) begin
            miscompares++;
            $display("[TB] FAIL rst_read: got %h want 22", got);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_packet();
        test_invalid_dest();
        test_full_fifo();
        test_back_to_back();
        test_timeout();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
